// File: rtl/decode_queue.sv
// Decoded-instruction buffer between the dual-issue decoder and the issue stage.
// Accepts up to two entries per cycle in program order and presents the two oldest.
module decode_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [1:0][WIDTH-1:0]         inst_i,
    input  logic [1:0]                    valid_i,
    output logic                          ready_o,
    output logic [1:0][WIDTH-1:0]         inst_o,
    output logic [1:0]                    valid_o,
    input  logic [1:0]                    issue_i,
    input  logic                          ex_ready_i,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    cnt;

    logic [1:0]       n_in;
    logic [1:0]       n_out;
    logic [1:0]       grant;

    // Handshake: ready_o depends on registered cnt only, so a same-cycle pop
    // never lets a push in; the decoder sees a stable accept signal all cycle.
    assign ready_o = (cnt <= CW'(DEPTH - 2));

    always_comb begin
        valid_o = 2'b00;
        if (cnt >= CW'(2)) begin
            valid_o = 2'b11;
        end else if (cnt == CW'(1)) begin
            valid_o = 2'b01;
        end
    end

    always_comb begin
        n_in = 2'd0;
        if (ready_o) begin
            if (valid_i == 2'b11) begin
                n_in = 2'd2;
            end else if (valid_i == 2'b01) begin
                n_in = 2'd1;
            end
        end
    end

    // Grant bits without a valid entry behind them are dropped; 10 counts as no grant.
    always_comb begin
        grant = 2'b00;
        n_out = 2'd0;
        if (ex_ready_i && issue_i != 2'b10) begin
            grant = issue_i & valid_o;
        end
        if (grant == 2'b11) begin
            n_out = 2'd2;
        end else if (grant == 2'b01) begin
            n_out = 2'd1;
        end
    end

    assign inst_o[0] = mem[rptr];
    assign inst_o[1] = mem[rptr + AW'(1)];
    assign count_o   = cnt;

    always_ff @(posedge clk) begin
        if (!flush_i && n_in != 2'd0) begin
            mem[wptr] <= inst_i[0];
            if (n_in == 2'd2) begin
                mem[wptr + AW'(1)] <= inst_i[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + AW'(n_in);
            rptr <= rptr + AW'(n_out);
            cnt  <= cnt + CW'(n_in) - CW'(n_out);
        end
    end

    a_valid_legal: assert property (@(posedge clk) disable iff (!rst_n) valid_i != 2'b10);
    a_issue_legal: assert property (@(posedge clk) disable iff (!rst_n) issue_i != 2'b10);
    a_cnt_range:   assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer contents.
module tb_decode_queue;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  flush_i;
    logic [1:0][WIDTH-1:0] inst_i;
    logic [1:0]            valid_i;
    logic                  ready_o;
    logic [1:0][WIDTH-1:0] inst_o;
    logic [1:0]            valid_o;
    logic [1:0]            issue_i;
    logic                  ex_ready_i;
    logic [$clog2(DEPTH):0] count_o;

    logic [WIDTH-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .inst_i     (inst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .inst_o     (inst_o),
        .valid_o    (valid_o),
        .issue_i    (issue_i),
        .ex_ready_i (ex_ready_i),
        .count_o    (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".count"}, 64'(count_o), 64'(sz));
        check({tag, ".valid"}, 64'(valid_o), (sz >= 2) ? 64'd3 : (sz == 1) ? 64'd1 : 64'd0);
        check({tag, ".ready"}, 64'(ready_o), 64'((DEPTH - sz) >= 2));
        if (sz >= 1) check({tag, ".inst0"}, 64'(inst_o[0]), 64'(exp_q[0]));
        if (sz >= 2) check({tag, ".inst1"}, 64'(inst_o[1]), 64'(exp_q[1]));
    endtask

    task automatic idle_inputs();
        valid_i = 2'b00; issue_i = 2'b00; ex_ready_i = 1'b0; flush_i = 1'b0;
        inst_i[0] = '0; inst_i[1] = '0;
    endtask

    // driver: one clock of traffic, model updated from the queue's rules
    task automatic step(input string tag, input logic [1:0] vin, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [1:0] iss, input logic exr,
                        input logic fl);
        int n_in, n_out, sz;
        @(negedge clk);
        valid_i = vin; inst_i[0] = a; inst_i[1] = b;
        issue_i = iss; ex_ready_i = exr; flush_i = fl;
        sz = exp_q.size();
        n_in = 0;
        if ((DEPTH - sz) >= 2) n_in = (vin == 2'b11) ? 2 : (vin == 2'b01) ? 1 : 0;
        n_out = 0;
        if (exr) n_out = (iss == 2'b11) ? 2 : (iss == 2'b01) ? 1 : 0;
        if (n_out > sz) n_out = sz;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < n_out; i++) void'(exp_q.pop_front());
            if (n_in >= 1) exp_q.push_back(a);
            if (n_in == 2) exp_q.push_back(b);
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        idle_inputs();
        #1;
        exp_q.delete();
        check("reset.count", 64'(count_o), 64'd0);
        check("reset.valid", 64'(valid_o), 64'd0);
        check("reset.ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [1:0] vin, iss;
        int r;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("por.count", 64'(count_o), 64'd0);
        check("por.valid", 64'(valid_o), 64'd0);
        check("por.ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // push pair then fill
        step("push_ab", 2'b11, 32'hA, 32'hB, 2'b00, 1'b0, 1'b0);
        check("push_ab.cnt2", 64'(count_o), 64'd2);
        step("fill1", 2'b11, 32'hC, 32'hD, 2'b00, 1'b0, 1'b0);
        step("fill2", 2'b11, 32'hE, 32'hF, 2'b00, 1'b0, 1'b0);
        step("fill3", 2'b11, 32'h10, 32'h11, 2'b00, 1'b0, 1'b0);
        check("full.count", 64'(count_o), 64'd8);
        check("full.ready", 64'(ready_o), 64'd0);
        step("push_full", 2'b11, 32'h12, 32'h13, 2'b00, 1'b0, 1'b0);
        check("push_full.inst0", 64'(inst_o[0]), 64'hA);
        check("push_full.count", 64'(count_o), 64'd8);

        // drain to three, then partial pops
        step("drain1", 2'b00, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0);
        step("drain2", 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
        step("drain3", 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
        check("drain.count3", 64'(count_o), 64'd3);
        step("pop1", 2'b00, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0);
        check("pop1.count2", 64'(count_o), 64'd2);
        step("stall", 2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
        check("stall.count2", 64'(count_o), 64'd2);

        // wrap: move both pointers to 6 with an empty queue
        do_reset();
        for (int i = 0; i < 3; i++) step("wrap_push", 2'b11, 32'h100 + i, 32'h200 + i, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("wrap_pop", 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
        step("wrap_xy", 2'b11, 32'h5858, 32'h5959, 2'b00, 1'b0, 1'b0);
        step("wrap_zw", 2'b11, 32'h5a5a, 32'h5757, 2'b11, 1'b1, 1'b0);
        check("wrap_zw.inst0", 64'(inst_o[0]), 64'h5a5a);
        check("wrap_zw.inst1", 64'(inst_o[1]), 64'h5757);
        check("wrap_zw.count", 64'(count_o), 64'd2);

        // flush beats push and pop
        step("pre_flush5", 2'b11, 32'h31, 32'h32, 2'b00, 1'b0, 1'b0);
        step("pre_flush5b", 2'b01, 32'h33, 32'h0, 2'b00, 1'b0, 1'b0);
        check("pre_flush.count5", 64'(count_o), 64'd5);
        step("flush", 2'b11, 32'h41, 32'h42, 2'b11, 1'b1, 1'b1);
        check("flush.count", 64'(count_o), 64'd0);
        check("flush.valid", 64'(valid_o), 64'd0);

        // over-grant against a single valid entry
        step("single", 2'b01, 32'h77, 32'h0, 2'b00, 1'b0, 1'b0);
        check("single.valid", 64'(valid_o), 64'd1);
        step("overgrant", 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
        check("overgrant.count", 64'(count_o), 64'd0);

        // mid-operation reset
        step("pre_rst", 2'b11, 32'h61, 32'h62, 2'b00, 1'b0, 1'b0);
        do_reset();
        step("post_rst", 2'b11, 32'h63, 32'h64, 2'b00, 1'b0, 1'b0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 2);
            vin = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            r = $urandom_range(0, 2);
            iss = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            a = $urandom;
            b = $urandom;
            step("rand", vin, a, b, iss, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
